// File: rtl/cpu_ctrl_if.sv
// Bus bundle between the multicycle control unit and its memories/ALU/regfile.
// master = control unit, slave = datapath/memory side.
interface cpu_ctrl_if #(
  parameter int PC_W = 8
);
  logic [PC_W-1:0] imem_addr;
  logic            imem_req;
  logic            imem_ack;
  logic [15:0]     imem_rdata;
  logic [3:0]      rf_ra1;
  logic [3:0]      rf_ra2;
  logic [3:0]      rf_wa;
  logic            rf_we;
  logic            rf_wsel;
  logic            alu_bsel;
  logic [15:0]     imm;
  logic [3:0]      aluctl;
  logic            btaken;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ack;
  logic            halted;

  modport master (
    output imem_addr, imem_req,
    input  imem_ack, imem_rdata,
    output rf_ra1, rf_ra2, rf_wa,
    output rf_we, rf_wsel,
    output alu_bsel, imm, aluctl,
    input  btaken,
    output dmem_req, dmem_we,
    input  dmem_ack,
    output halted
  );

  modport slave (
    input  imem_addr, imem_req,
    output imem_ack, imem_rdata,
    input  rf_ra1, rf_ra2, rf_wa,
    input  rf_we, rf_wsel,
    input  alu_bsel, imm, aluctl,
    output btaken,
    input  dmem_req, dmem_we,
    output dmem_ack,
    input  halted
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle control unit: fetch/decode/exec/mem/wb sequencing, owns the PC.
// Ports: clk, rst_n (async active-low), bus (cpu_ctrl_if.master).
module cpu_ctrl_fsm #(
  parameter int          PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  cpu_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;

  logic [3:0]      op;
  logic            is_r;
  logic            is_br;
  logic            is_addi;
  logic            is_ld;
  logic            is_st;
  logic            is_halt;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] br_tgt;

  assign op      = ir_q[15:12];
  assign is_r    = ~op[3];
  assign is_br   = (op[3:2] == 2'b10);
  assign is_addi = (op == 4'hC);
  assign is_ld   = (op == 4'hD);
  assign is_st   = (op == 4'hE);
  assign is_halt = (op == 4'hF);

  assign pc_inc = pc_q + PC_W'(1);
  assign br_off = {{(PC_W-4){ir_q[3]}}, ir_q[3:0]};
  assign br_tgt = pc_inc + br_off;

  // Register addresses decode from ir at all times; branches and
  // stores move their sources up into the rd field.
  assign bus.rf_ra1 = is_br ? ir_q[11:8] : ir_q[7:4];
  assign bus.rf_ra2 = is_br ? ir_q[7:4]
                    : is_st ? ir_q[11:8]
                    : ir_q[3:0];
  assign bus.rf_wa     = ir_q[11:8];
  assign bus.imm       = {12'h000, ir_q[3:0]};
  assign bus.imem_addr = pc_q;
  assign bus.halted    = (state_q == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= PC_W'(RESET_PC);
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.dmem_we  = 1'b0;
    bus.rf_we    = 1'b0;
    bus.rf_wsel  = 1'b0;
    bus.aluctl   = 4'h0;
    bus.alu_bsel = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        // Gated so the request is low while reset is held.
        bus.imem_req = rst_n;
        if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = is_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        bus.aluctl   = (is_r | is_br) ? op : 4'h0;
        bus.alu_bsel = is_addi | is_ld | is_st;
        unique case (1'b1)
          is_br: begin
            pc_d    = bus.btaken ? br_tgt : pc_inc;
            state_d = S_FETCH;
          end
          is_ld,
          is_st: state_d = S_MEM;
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = is_st;
        if (bus.dmem_ack) begin
          if (is_st) begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        bus.rf_we   = 1'b1;
        bus.rf_wsel = is_ld;
        pc_d        = pc_inc;
        state_d     = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed scoreboard bench for cpu_ctrl_fsm.
// Expected fetch addresses and writebacks are queued at issue.
module tb_cpu_ctrl_fsm;
  localparam int PC_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_ctrl_if #(.PC_W(PC_W)) bus ();

  cpu_ctrl_fsm #(
    .PC_W(PC_W),
    .RESET_PC(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  logic [PC_W-1:0] addr_q[$];
  logic [4:0]      wb_q[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ra1_of(input logic [15:0] i);
    if (i[15:14] == 2'b10) return i[11:8];
    return i[7:4];
  endfunction

  function automatic logic [3:0] ra2_of(input logic [15:0] i);
    if (i[15:14] == 2'b10) return i[7:4];
    if (i[15:12] == 4'hE) return i[11:8];
    return i[3:0];
  endfunction

  task automatic reset_model();
    addr_q.delete();
    wb_q.delete();
    addr_q.push_back('0);
  endtask

  // Entered at a falling edge with the DUT in FETCH; leaves in DECODE.
  task automatic do_fetch(input logic [15:0] ins, input int iw);
    logic [PC_W-1:0] a;
    a = (addr_q.size() > 0) ? addr_q.pop_front() : 'x;
    chk("fetch_req", 32'(bus.imem_req), 1);
    chk("fetch_addr", 32'(bus.imem_addr), 32'(a));
    chk("fetch_rf_we", 32'(bus.rf_we), 0);
    chk("fetch_dmem_req", 32'(bus.dmem_req), 0);
    bus.imem_ack = 1'b0;
    for (int i = 0; i < iw; i++) begin
      @(negedge clk);
      chk("iwait_req", 32'(bus.imem_req), 1);
      chk("iwait_addr", 32'(bus.imem_addr), 32'(a));
      chk("iwait_idle",
          {25'd0, bus.rf_we, bus.dmem_req, bus.dmem_we, bus.aluctl}, 0);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = ins;
    @(negedge clk);
    bus.imem_ack = 1'b0;
  endtask

  task automatic run(input logic [15:0] ins, input logic bt,
                     input int iw, input int dw,
                     input logic [PC_W-1:0] nxt);
    logic [3:0] op;
    op = ins[15:12];
    do_fetch(ins, iw);
    chk("dec_req", 32'(bus.imem_req), 0);
    chk("dec_ra1", 32'(bus.rf_ra1), 32'(ra1_of(ins)));
    chk("dec_ra2", 32'(bus.rf_ra2), 32'(ra2_of(ins)));
    chk("dec_imm", 32'(bus.imm), {28'd0, ins[3:0]});
    if (op == 4'hF) return;
    addr_q.push_back(nxt);
    if (op != 4'hE && op[3:2] != 2'b10)
      wb_q.push_back({op == 4'hD, ins[11:8]});
    @(negedge clk);
    chk("ex_aluctl", 32'(bus.aluctl), (op < 4'hC) ? 32'(op) : 0);
    chk("ex_bsel", 32'(bus.alu_bsel), (op >= 4'hC) ? 1 : 0);
    bus.btaken = bt;
    @(negedge clk);
    bus.btaken = 1'b0;
    if (op == 4'hD || op == 4'hE) begin
      for (int i = 0; i <= dw; i++) begin
        chk("mem_req", 32'(bus.dmem_req), 1);
        chk("mem_we", 32'(bus.dmem_we), (op == 4'hE) ? 1 : 0);
        chk("mem_rf_we", 32'(bus.rf_we), 0);
        bus.dmem_ack = (i == dw);
        @(negedge clk);
      end
      bus.dmem_ack = 1'b0;
    end
    if (op != 4'hE && op[3:2] != 2'b10) begin
      logic [4:0] w;
      w = (wb_q.size() > 0) ? wb_q.pop_front() : 'x;
      chk("wb_we", 32'(bus.rf_we), 1);
      chk("wb_wa_wsel", {27'd0, bus.rf_wsel, bus.rf_wa}, 32'(w));
      chk("wb_dmem_req", 32'(bus.dmem_req), 0);
      @(negedge clk);
    end
  endtask

  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'h0000;
    bus.btaken     = 1'b0;
    bus.dmem_ack   = 1'b0;
    reset_model();
    #12;
    chk("rst_imem_req", 32'(bus.imem_req), 0);
    chk("rst_addr", 32'(bus.imem_addr), 0);
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_idle",
        {24'd0, bus.rf_we, bus.rf_wsel, bus.dmem_req,
         bus.alu_bsel, bus.aluctl}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(16'h0312, 1'b0, 0, 0, 8'd1);
    run(16'hC215, 1'b0, 0, 0, 8'd2);
    run(16'hE214, 1'b0, 0, 0, 8'd3);
    run(16'hD214, 1'b0, 0, 3, 8'd4);
    run(16'h8123, 1'b1, 0, 0, 8'd8);
    run(16'h8123, 1'b0, 0, 0, 8'd9);
    run(16'h1456, 1'b0, 5, 0, 8'd10);
    run(16'hB12E, 1'b1, 0, 0, 8'd9);
    run(16'h9000, 1'b0, 0, 0, 8'd10);

    #2 rst_n = 1'b0;
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(16'h912F, 1'b1, 0, 0, 8'd0);
    run(16'h912E, 1'b1, 0, 0, 8'd255);
    run(16'h0312, 1'b0, 0, 0, 8'd0);

    do_fetch(16'hD214, 0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_dmem_req", 32'(bus.dmem_req), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_dmem_req", 32'(bus.dmem_req), 0);
    chk("async_imem_req", 32'(bus.imem_req), 0);
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(16'hF000, 1'b0, 0, 0, 8'd0);
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("halt_halted", 32'(bus.halted), 1);
      chk("halt_reqs", {30'd0, bus.imem_req, bus.dmem_req}, 0);
      chk("halt_rf_we", 32'(bus.rf_we), 0);
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("unhalt", 32'(bus.halted), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req", 32'(bus.imem_req), 1);
    chk("post_rst_addr", 32'(bus.imem_addr), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
